// File: rtl/sobel_pkg.sv
// Shared types, widths and the RGB-to-gray helper for the Sobel front end.
package sobel_pkg;

    localparam int PIX_W = 8;
    localparam int RGB_W = 24;
    localparam int LB_W  = PIX_W + RGB_W;

    localparam logic [7:0] GRAY_COEF_R = 8'd77;
    localparam logic [7:0] GRAY_COEF_G = 8'd150;
    localparam logic [7:0] GRAY_COEF_B = 8'd29;

    typedef struct packed {
        logic [PIX_W-1:0] a11, a12, a13;
        logic [PIX_W-1:0] a21, a22, a23;
        logic [PIX_W-1:0] a31, a32, a33;
    } win3x3_t;

    // Coefficients sum to 256, so the 16-bit sum cannot overflow.
    function automatic logic [PIX_W-1:0] rgb2gray(input logic [RGB_W-1:0] rgb);
        logic [15:0] sum;
        sum = 16'(GRAY_COEF_R) * 16'(rgb[23:16])
            + 16'(GRAY_COEF_G) * 16'(rgb[15:8])
            + 16'(GRAY_COEF_B) * 16'(rgb[7:0]);
        return sum[15:8];
    endfunction

endpackage

// File: rtl/sobel_window_gen_if.sv
// Input pixel stream and 3x3 window output bundles of the Sobel front end.
interface pix_stream_if;
    import sobel_pkg::*;

    logic [RGB_W-1:0] pix_rgb;
    logic             pix_sof;
    logic             pix_valid;
    logic             pix_ready;

    modport master (output pix_rgb, pix_sof, pix_valid, input pix_ready);
    modport slave  (input pix_rgb, pix_sof, pix_valid, output pix_ready);
endinterface

interface sobel_win_if;
    import sobel_pkg::*;

    logic [RGB_W-1:0] data_m_rgb;
    logic [PIX_W-1:0] a11, a12, a13, a21, a22, a23, a31, a32, a33;
    logic             zero_valid;
    logic             valid_m;
    logic             ready_m;

    modport master (output data_m_rgb, a11, a12, a13, a21, a22, a23, a31, a32, a33,
                    output zero_valid, valid_m, input ready_m);
    modport slave  (input data_m_rgb, a11, a12, a13, a21, a22, a23, a31, a32, a33,
                    input zero_valid, valid_m, output ready_m);
endinterface

// File: rtl/sobel_line_buf.sv
// One line of {gray,rgb}: synchronous write, combinational read (old data on collision).
module sobel_line_buf
    import sobel_pkg::*;
#(
    parameter int DEPTH  = 640,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [LB_W-1:0]   wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [LB_W-1:0]   rd_data
);

    logic [LB_W-1:0] mem [DEPTH];

    assign rd_data = mem[rd_addr];

    // NOTE: storage arrays carry no reset; a reset branch would turn the RAM into flops.
    always_ff @(posedge clk) begin
        if (we) mem[wr_addr] <= wr_data;
    end

endmodule

// File: rtl/sobel_window_gen.sv
// Raster RGB stream to 3x3 gray window plus centre RGB, one-deep registered output.
module sobel_window_gen
    import sobel_pkg::*;
#(
    parameter int IMG_W = 640,
    parameter int IMG_H = 480
) (
    input  logic       clk,
    input  logic       rst_n,
    pix_stream_if.slave pix,
    sobel_win_if.master win
);

    localparam int COL_W = $clog2(IMG_W);
    localparam int ROW_W = $clog2(IMG_H);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);

    logic [COL_W-1:0] col, cur_col;
    logic [ROW_W-1:0] row, cur_row;
    logic             ready, accept, border;
    logic [PIX_W-1:0] gray;
    logic [LB_W-1:0]  lb0_rd;
    logic [PIX_W-1:0] lb1_gray;
    logic [RGB_W-1:0] lb1_rgb_unused;
    win3x3_t          win_q;
    logic [RGB_W-1:0] c23_rgb, out_rgb;
    logic             out_valid, out_zero;

    assign ready  = ~out_valid | win.ready_m;
    assign accept = pix.pix_valid & ready;
    assign gray   = rgb2gray(pix.pix_rgb);

    // A start-of-frame pixel is placed at the origin regardless of the counters.
    assign cur_col = pix.pix_sof ? '0 : col;
    assign cur_row = pix.pix_sof ? '0 : row;
    assign border  = (cur_col < COL_W'(2)) | (cur_row < ROW_W'(2));

    sobel_line_buf #(.DEPTH(IMG_W), .ADDR_W(COL_W)) u_lb0 (
        .clk     (clk),
        .we      (accept),
        .wr_addr (cur_col),
        .wr_data ({gray, pix.pix_rgb}),
        .rd_addr (cur_col),
        .rd_data (lb0_rd)
    );

    sobel_line_buf #(.DEPTH(IMG_W), .ADDR_W(COL_W)) u_lb1 (
        .clk     (clk),
        .we      (accept),
        .wr_addr (cur_col),
        .wr_data (lb0_rd),
        .rd_addr (cur_col),
        .rd_data ({lb1_gray, lb1_rgb_unused})
    );

    // NOTE: registers use non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col <= '0;
            row <= '0;
        end else if (accept) begin
            if (cur_col == COL_LAST) begin
                col <= '0;
                row <= (cur_row == ROW_LAST) ? '0 : cur_row + 1'b1;
            end else begin
                col <= cur_col + 1'b1;
                row <= cur_row;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_q     <= '0;
            c23_rgb   <= '0;
            out_rgb   <= '0;
            out_zero  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            if (accept) begin
                win_q.a11 <= win_q.a12;
                win_q.a12 <= win_q.a13;
                win_q.a13 <= lb1_gray;
                win_q.a21 <= win_q.a22;
                win_q.a22 <= win_q.a23;
                win_q.a23 <= lb0_rd[LB_W-1:RGB_W];
                win_q.a31 <= win_q.a32;
                win_q.a32 <= win_q.a33;
                win_q.a33 <= gray;
                // Old a23 RGB becomes the new centre as the taps shift left.
                c23_rgb   <= lb0_rd[RGB_W-1:0];
                out_rgb   <= border ? '0 : c23_rgb;
                out_zero  <= border;
                out_valid <= 1'b1;
            end else if (win.ready_m) begin
                out_valid <= 1'b0;
            end
        end
    end

    assign pix.pix_ready  = ready;
    assign win.valid_m    = out_valid;
    assign win.zero_valid = out_zero;
    assign win.data_m_rgb = out_rgb;
    assign win.a11 = win_q.a11;
    assign win.a12 = win_q.a12;
    assign win.a13 = win_q.a13;
    assign win.a21 = win_q.a21;
    assign win.a22 = win_q.a22;
    assign win.a23 = win_q.a23;
    assign win.a31 = win_q.a31;
    assign win.a32 = win_q.a32;
    assign win.a33 = win_q.a33;

endmodule

// File: tb/tb_sobel_window_gen.sv
// Self-checking bench for sobel_window_gen on a 4x3 frame against a frame-array model.
module tb_sobel_window_gen;

    localparam int IMG_W = 4;
    localparam int IMG_H = 3;

    typedef struct {
        logic        zero;
        logic [23:0] rgb;
        logic [71:0] taps;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    exp_t        q[$];
    int          mx = 0;
    int          my = 0;
    logic [7:0]  g_img [IMG_H][IMG_W];
    logic [23:0] c_img [IMG_H][IMG_W];

    pix_stream_if pix_if ();
    sobel_win_if  win_if ();

    sobel_window_gen #(.IMG_W(IMG_W), .IMG_H(IMG_H)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .pix   (pix_if),
        .win   (win_if)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] gray_of(input logic [23:0] rgb);
        int sum;
        sum = 77 * int'(rgb[23:16]) + 150 * int'(rgb[15:8]) + 29 * int'(rgb[7:0]);
        return 8'(sum / 256);
    endfunction

    function automatic logic [71:0] taps_now();
        return {win_if.a11, win_if.a12, win_if.a13, win_if.a21, win_if.a22,
                win_if.a23, win_if.a31, win_if.a32, win_if.a33};
    endfunction

    // Called mid-cycle: check what is on the output now, then account for this edge.
    task automatic model_step(output logic acc);
        exp_t e;
        check("valid_m", 72'(win_if.valid_m), 72'(q.size() != 0));
        check("pix_ready", 72'(pix_if.pix_ready), 72'((q.size() == 0) || win_if.ready_m));
        if (q.size() != 0) begin
            e = q[0];
            check("zero_valid", 72'(win_if.zero_valid), 72'(e.zero));
            check("data_m_rgb", 72'(win_if.data_m_rgb), 72'(e.rgb));
            if (!e.zero) check("window", taps_now(), e.taps);
            if (win_if.ready_m) void'(q.pop_front());
        end
        acc = pix_if.pix_valid & pix_if.pix_ready;
        if (acc) begin
            if (pix_if.pix_sof) begin
                mx = 0;
                my = 0;
            end
            g_img[my][mx] = gray_of(pix_if.pix_rgb);
            c_img[my][mx] = pix_if.pix_rgb;
            e.zero = (mx < 2) || (my < 2);
            e.rgb  = e.zero ? 24'h0 : c_img[my-1][mx-1];
            e.taps = '0;
            if (!e.zero)
                for (int dr = 0; dr < 3; dr++)
                    for (int dc = 0; dc < 3; dc++)
                        e.taps = {e.taps[63:0], g_img[my-2+dr][mx-2+dc]};
            q.push_back(e);
            mx++;
            if (mx == IMG_W) begin
                mx = 0;
                my = (my == IMG_H - 1) ? 0 : my + 1;
            end
        end
    endtask

    task automatic cycle(input logic v, input logic s, input logic [23:0] rgb,
                         input logic rdy, output logic acc);
        pix_if.pix_valid = v;
        pix_if.pix_sof   = s;
        pix_if.pix_rgb   = rgb;
        win_if.ready_m   = rdy;
        @(negedge clk);
        model_step(acc);
        @(posedge clk);
        #1;
    endtask

    logic        acc;
    logic [23:0] rgbs [24];
    logic [71:0] held_taps;
    logic [23:0] held_rgb;
    logic [23:0] colors [4];
    logic [7:0]  grays [4];
    int          idx;
    int          n;

    initial begin
        pix_if.pix_valid = 1'b0;
        pix_if.pix_sof   = 1'b0;
        pix_if.pix_rgb   = '0;
        win_if.ready_m   = 1'b1;
        colors = '{24'hFF0000, 24'h00FF00, 24'h0000FF, 24'hFFFFFF};
        grays  = '{8'd76, 8'd149, 8'd28, 8'd255};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid_m", 72'(win_if.valid_m), 72'(0));
        check("rst_zero_valid", 72'(win_if.zero_valid), 72'(1));
        check("rst_data_m_rgb", 72'(win_if.data_m_rgb), 72'(0));
        check("rst_taps", taps_now(), 72'(0));
        rst_n = 1'b1;
        #1;
        check("rst_pix_ready", 72'(pix_if.pix_ready), 72'(1));
        @(posedge clk);
        #1;

        // Gray-ramp frame: pixel i has R=G=B=i
        for (int i = 0; i < 12; i++) begin
            cycle(1'b1, i == 0, {8'(i), 8'(i), 8'(i)}, 1'b1, acc);
            check($sformatf("ramp_zv_%0d", i), 72'(win_if.zero_valid), 72'(i < 10));
            if (i == 10) check("ramp_rgb_10", 72'(win_if.data_m_rgb), 72'(24'h050505));
        end
        check("ramp_taps_11", taps_now(), {8'd1, 8'd2, 8'd3, 8'd5, 8'd6, 8'd7, 8'd9, 8'd10, 8'd11});
        check("ramp_rgb_11", 72'(win_if.data_m_rgb), 72'(24'h060606));

        // Gray conversion of primaries at the two in-frame positions of a frame
        for (int f = 0; f < 2; f++)
            for (int i = 0; i < 12; i++) begin
                cycle(1'b1, i == 0, (i >= 10) ? colors[2*f + i - 10] : 24'($urandom), 1'b1, acc);
                if (i >= 10)
                    check($sformatf("gray_%0d", 2*f + i - 10), 72'(win_if.a33), 72'(grays[2*f + i - 10]));
            end

        // Back-pressure for 5 cycles with pixel 11 offered
        for (int i = 0; i < 12; i++) rgbs[i] = 24'($urandom);
        for (int i = 0; i < 11; i++) cycle(1'b1, i == 0, rgbs[i], 1'b1, acc);
        held_taps = taps_now();
        held_rgb  = win_if.data_m_rgb;
        for (int k = 0; k < 5; k++) begin
            cycle(1'b1, 1'b0, rgbs[11], 1'b0, acc);
            check("stall_valid", 72'(win_if.valid_m), 72'(1));
            check("stall_ready", 72'(pix_if.pix_ready), 72'(0));
            check("stall_taps", taps_now(), held_taps);
            check("stall_rgb", 72'(win_if.data_m_rgb), 72'(held_rgb));
        end
        cycle(1'b1, 1'b0, rgbs[11], 1'b1, acc);

        // Two frames with random bubbles and back-pressure
        for (int i = 0; i < 24; i++) rgbs[i] = 24'($urandom);
        idx = 0;
        n   = 0;
        while (idx < 24 && n < 600) begin
            cycle(1'($urandom_range(0, 1)), (idx % 12) == 0, rgbs[idx],
                  $urandom_range(0, 3) != 0, acc);
            if (acc) idx++;
            n++;
        end
        check("random_budget", 72'(idx), 72'(24));

        // Mid-frame start-of-frame at pixel 6
        for (int i = 0; i < 6; i++) cycle(1'b1, i == 0, 24'($urandom), 1'b1, acc);
        for (int i = 0; i < 8; i++) begin
            cycle(1'b1, i == 0, 24'($urandom), 1'b1, acc);
            check($sformatf("sof_zv_%0d", i), 72'(win_if.zero_valid), 72'(1));
        end
        for (int i = 8; i < 12; i++) cycle(1'b1, 1'b0, 24'($urandom), 1'b1, acc);

        // Asynchronous reset mid-line
        for (int i = 0; i < 2; i++) cycle(1'b1, i == 0, 24'($urandom), 1'b1, acc);
        pix_if.pix_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check("arst_valid_m", 72'(win_if.valid_m), 72'(0));
        check("arst_zero_valid", 72'(win_if.zero_valid), 72'(1));
        q.delete();
        mx = 0;
        my = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) cycle(1'b1, 1'b0, 24'($urandom), 1'b1, acc);
        check("arst_frame_zv", 72'(win_if.zero_valid), 72'(0));

        // Drain
        n = 0;
        while (q.size() != 0 && n < 8) begin
            cycle(1'b0, 1'b0, 24'h0, 1'b1, acc);
            n++;
        end
        check("drain_empty", 72'(q.size()), 72'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
